// File: rtl/pico_bus_pkg.sv
// Shared types for the PicoRV32 native-bus arbiter: FSM states and
// request/response bundles.
package pico_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TOUT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } pico_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
  } pico_rsp_t;

endpackage

// File: rtl/pico_arbiter_2_1_if.sv
// Bus bundle around the 2:1 arbiter: two upstream master ports (picom0/picom1)
// and the single downstream port (picom) feeding the address-decode mux.
interface pico_arbiter_2_1_if;
  // PicoRV32 native handshake: a master raises valid with addr/wdata/wstrb and
  // holds them stable until ready is seen high for one cycle; wstrb==0 is a read.
  logic        picom0_valid;
  logic [31:0] picom0_addr;
  logic [31:0] picom0_wdata;
  logic [3:0]  picom0_wstrb;
  logic        picom0_ready;
  logic [31:0] picom0_rdata;

  logic        picom1_valid;
  logic [31:0] picom1_addr;
  logic [31:0] picom1_wdata;
  logic [3:0]  picom1_wstrb;
  logic        picom1_ready;
  logic [31:0] picom1_rdata;

  logic        picom_valid;
  logic [31:0] picom_addr;
  logic [31:0] picom_wdata;
  logic [3:0]  picom_wstrb;
  logic        picom_ready;
  logic [31:0] picom_rdata;

  // Arbiter view.
  modport slave (
    input  picom0_valid, picom0_addr, picom0_wdata, picom0_wstrb,
    input  picom1_valid, picom1_addr, picom1_wdata, picom1_wstrb,
    output picom0_ready, picom0_rdata, picom1_ready, picom1_rdata,
    output picom_valid, picom_addr, picom_wdata, picom_wstrb,
    input  picom_ready, picom_rdata
  );

  // Environment view: the two masters plus the downstream mux.
  modport master (
    output picom0_valid, picom0_addr, picom0_wdata, picom0_wstrb,
    output picom1_valid, picom1_addr, picom1_wdata, picom1_wstrb,
    input  picom0_ready, picom0_rdata, picom1_ready, picom1_rdata,
    input  picom_valid, picom_addr, picom_wdata, picom_wstrb,
    output picom_ready, picom_rdata
  );
endinterface

// File: rtl/pico_rr_arb2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to
// the master that was not granted last.
module pico_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt,
  output logic       any
);
  always_comb begin
    any = |req;
    gnt = req[1] & (~req[0] | ~last_gnt);
  end
endmodule

// File: rtl/pico_arbiter_2_1.sv
// Two-master to one-slave arbiter for the PicoRV32 native bus with
// transaction-long round-robin grant and a bus-timeout watchdog.
module pico_arbiter_2_1
  import pico_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst,
  pico_arbiter_2_1_if.slave bus,
  input  logic              timeout_clr,
  output logic              timeout_err,
  output logic [31:0]       timeout_addr,
  output logic              timeout_master,
  output arb_state_t        dbg_state,
  output logic              dbg_gnt
);
  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  arb_state_t    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_err_q, timeout_err_d;
  logic [31:0]   timeout_addr_q, timeout_addr_d;
  logic          timeout_master_q, timeout_master_d;

  pico_req_t req [2];
  pico_rsp_t rsp [2];
  pico_req_t sel;
  pico_req_t out_req;
  logic      pick_gnt, pick_any;

  assign req[0] = '{valid: bus.picom0_valid, addr: bus.picom0_addr,
                    wdata: bus.picom0_wdata, wstrb: bus.picom0_wstrb};
  assign req[1] = '{valid: bus.picom1_valid, addr: bus.picom1_addr,
                    wdata: bus.picom1_wdata, wstrb: bus.picom1_wstrb};
  assign sel    = req[gnt_q];

  pico_rr_arb2 u_pick (
    .req      ({req[1].valid, req[0].valid}),
    .last_gnt (last_gnt_q),
    .gnt      (pick_gnt),
    .any      (pick_any)
  );

  // Data path: only the granted master is connected; TOUT fakes the completion.
  always_comb begin
    out_req = '0;
    rsp[0]  = '0;
    rsp[1]  = '0;
    case (state_q)
      GRANT: begin
        out_req      = sel;
        rsp[gnt_q]   = '{ready: bus.picom_ready, rdata: bus.picom_rdata};
      end
      TOUT:    rsp[gnt_q] = '{ready: 1'b1, rdata: TIMEOUT_RDATA};
      default: ;
    endcase
  end

  assign bus.picom_valid  = out_req.valid;
  assign bus.picom_addr   = out_req.addr;
  assign bus.picom_wdata  = out_req.wdata;
  assign bus.picom_wstrb  = out_req.wstrb;
  assign bus.picom0_ready = rsp[0].ready;
  assign bus.picom0_rdata = rsp[0].rdata;
  assign bus.picom1_ready = rsp[1].ready;
  assign bus.picom1_rdata = rsp[1].rdata;

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    last_gnt_d       = last_gnt_q;
    cnt_d            = cnt_q;
    timeout_addr_d   = timeout_addr_q;
    timeout_master_d = timeout_master_q;
    timeout_err_d    = timeout_clr ? 1'b0 : timeout_err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Slave ready beats expiry; a dropped request is abandoned without
        // advancing round-robin priority.
        if (bus.picom_ready) begin
          state_d    = IDLE;
          last_gnt_d = gnt_q;
        end else if (!sel.valid) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
          state_d = TOUT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TOUT: begin
        state_d          = IDLE;
        last_gnt_d       = gnt_q;
        timeout_err_d    = 1'b1;
        timeout_addr_d   = sel.addr;
        timeout_master_d = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      gnt_q            <= 1'b0;
      last_gnt_q       <= 1'b1;
      cnt_q            <= '0;
      timeout_err_q    <= 1'b0;
      timeout_addr_q   <= '0;
      timeout_master_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      last_gnt_q       <= last_gnt_d;
      cnt_q            <= cnt_d;
      timeout_err_q    <= timeout_err_d;
      timeout_addr_q   <= timeout_addr_d;
      timeout_master_q <= timeout_master_d;
    end
  end

  assign timeout_err    = timeout_err_q;
  assign timeout_addr   = timeout_addr_q;
  assign timeout_master = timeout_master_q;
  assign dbg_state      = state_q;
  assign dbg_gnt        = gnt_q;
endmodule

// File: tb/tb_pico_arbiter_2_1.sv
// Self-checking bench for pico_arbiter_2_1: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_pico_arbiter_2_1;
  import pico_bus_pkg::*;

  localparam int          T        = 8;
  localparam logic [31:0] TO_RDATA = 32'hDEAD_BEEF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        timeout_clr;
  logic        timeout_err;
  logic [31:0] timeout_addr;
  logic        timeout_master;
  arb_state_t  dbg_state;
  logic        dbg_gnt;

  always #5 clk = ~clk;

  pico_arbiter_2_1_if bus ();

  pico_arbiter_2_1 #(.TIMEOUT_CYCLES(T), .TIMEOUT_RDATA(TO_RDATA)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .timeout_clr    (timeout_clr),
    .timeout_err    (timeout_err),
    .timeout_addr   (timeout_addr),
    .timeout_master (timeout_master),
    .dbg_state      (dbg_state),
    .dbg_gnt        (dbg_gnt)
  );

  // ---------------- stimulus state ----------------
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        sr;
  logic [31:0] srd;
  logic        clr_in;
  logic        rst_in;

  // ---------------- reference model ----------------
  int          owner;     // -1: nobody holds the bus
  int          age;       // granted cycles spent without a response
  bit          m_tout;
  bit          m_last;
  bit          m_err;
  logic [31:0] m_taddr;
  bit          m_tmaster;

  // ---------------- scoreboard ----------------
  logic [1:0]  exp_q [$];
  logic [1:0]  got_q [$];
  logic        exp_rdy [2];
  logic        obs_rdy [2];
  logic [31:0] obs_rdata [2];
  logic        obs_err, obs_valid, obs_tmaster;
  logic [31:0] obs_addr, obs_taddr;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    owner     = -1;
    age       = 0;
    m_tout    = 1'b0;
    m_last    = 1'b1;
    m_err     = 1'b0;
    m_taddr   = '0;
    m_tmaster = 1'b0;
  endtask

  task automatic apply_inputs();
    bus.picom0_valid = mv[0]; bus.picom0_addr = ma[0]; bus.picom0_wdata = mw[0]; bus.picom0_wstrb = ms[0];
    bus.picom1_valid = mv[1]; bus.picom1_addr = ma[1]; bus.picom1_wdata = mw[1]; bus.picom1_wstrb = ms[1];
    bus.picom_ready  = sr;
    bus.picom_rdata  = srd;
    timeout_clr      = clr_in;
    rst              = rst_in;
  endtask

  // One clock: drive, check mid-cycle against the model, advance the model.
  task automatic step();
    logic        ev;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic        er [2];
    logic [31:0] erd [2];
    arb_state_t  est;
    bit          sets;
    apply_inputs();
    #1;
    ev = 1'b0; ea = '0; ew = '0; es = '0; est = IDLE;
    er[0] = 1'b0; er[1] = 1'b0; erd[0] = '0; erd[1] = '0;
    if (owner >= 0 && m_tout) begin
      est = TOUT;
      er[owner] = 1'b1;
      erd[owner] = TO_RDATA;
    end else if (owner >= 0) begin
      est = GRANT;
      ev = mv[owner]; ea = ma[owner]; ew = mw[owner]; es = ms[owner];
      er[owner] = sr;
      erd[owner] = srd;
      check("gnt", 32'(dbg_gnt), 32'(owner));
    end
    check("state", 32'(dbg_state), 32'(est));
    check("picom_valid", 32'(bus.picom_valid), 32'(ev));
    check("picom_addr", bus.picom_addr, ea);
    check("picom_wdata", bus.picom_wdata, ew);
    check("picom_wstrb", 32'(bus.picom_wstrb), 32'(es));
    check("m0_ready", 32'(bus.picom0_ready), 32'(er[0]));
    check("m0_rdata", bus.picom0_rdata, erd[0]);
    check("m1_ready", 32'(bus.picom1_ready), 32'(er[1]));
    check("m1_rdata", bus.picom1_rdata, erd[1]);
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("timeout_addr", timeout_addr, m_taddr);
    check("timeout_master", 32'(timeout_master), 32'(m_tmaster));
    exp_rdy[0] = er[0]; exp_rdy[1] = er[1];
    obs_rdy[0] = bus.picom0_ready; obs_rdy[1] = bus.picom1_ready;
    obs_rdata[0] = bus.picom0_rdata; obs_rdata[1] = bus.picom1_rdata;
    obs_valid = bus.picom_valid; obs_addr = bus.picom_addr;
    obs_err = timeout_err; obs_taddr = timeout_addr; obs_tmaster = timeout_master;
    @(posedge clk);
    sets = 1'b0;
    if (rst_in) begin
      reset_model();
    end else begin
      if (owner < 0) begin
        if (mv[0] || mv[1]) begin
          owner = (mv[0] && mv[1]) ? int'(!m_last) : (mv[1] ? 1 : 0);
          age = 0;
        end
      end else if (m_tout) begin
        sets = 1'b1;
        m_taddr = ma[owner];
        m_tmaster = owner[0];
        m_last = owner[0];
        m_tout = 1'b0;
        owner = -1;
      end else if (sr) begin
        m_last = owner[0];
        owner = -1;
      end else if (!mv[owner]) begin
        owner = -1;
      end else if (age == T - 1) begin
        m_tout = 1'b1;
      end else begin
        age++;
      end
      if (sets) m_err = 1'b1;
      else if (clr_in) m_err = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
    end
    sr = 1'b0; srd = '0; clr_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, prev, c0;
    logic [31:0] t_rdata;
    bit stall;
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_in = 1'b1;
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_model();
    step();                       // reset values while rst is held
    rst_in = 1'b0;

    // Single CPU read, slave answers on the third granted cycle.
    mv[0] = 1'b1; ma[0] = 32'h4000_0010; mw[0] = 32'h0; ms[0] = 4'h0;
    step(); step(); step();
    sr = 1'b1; srd = 32'h1234_5678;
    step();
    check("t1_m0_ready", 32'(obs_rdy[0]), 32'd1);
    check("t1_m0_rdata", obs_rdata[0], 32'h1234_5678);
    check("t1_m1_ready", 32'(obs_rdy[1]), 32'd0);
    idle_inputs();
    step();

    // Both masters hold valid: grants alternate with one idle bubble.
    rst_in = 1'b1; step(); rst_in = 1'b0;
    mv[0] = 1'b1; ma[0] = 32'h0000_1000; ms[0] = 4'h0;
    mv[1] = 1'b1; ma[1] = 32'h0000_2000; ms[1] = 4'h3; mw[1] = 32'hCAFE_0001;
    sr = 1'b1;
    prev = -1;
    for (int c = 0; c < 20 && got_q.size() < 4; c++) begin
      srd = $urandom;
      step();
      if (obs_rdy[0] || obs_rdy[1]) begin
        got_q.push_back(obs_rdy[1] ? 2'd1 : 2'd0);
        if (prev >= 0) check("t2_gap", 32'(c - prev), 32'd2);
        prev = c;
      end
    end
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
    check("t2_count", 32'(got_q.size()), 32'd4);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("t2_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    idle_inputs();
    step();

    // Timeout on an unanswered m1 write, then clear-vs-set.
    mv[1] = 1'b1; ma[1] = 32'hF000_0000; mw[1] = $urandom; ms[1] = 4'hF;
    lat = -1; t_rdata = '0;
    for (int c = 0; c < 10; c++) begin
      clr_in = (c == 9);
      step();
      if (obs_rdy[1] && lat < 0) begin
        lat = c;
        t_rdata = obs_rdata[1];
      end
    end
    check("t3_latency", 32'(lat), 32'd9);
    check("t3_rdata", t_rdata, TO_RDATA);
    mv[1] = 1'b0;
    step();
    check("t3_err_set_wins", 32'(obs_err), 32'd1);
    check("t3_taddr", obs_taddr, 32'hF000_0000);
    check("t3_tmaster", 32'(obs_tmaster), 32'd1);
    clr_in = 1'b0;
    step();
    check("t3_err_cleared", 32'(obs_err), 32'd0);
    check("t3_taddr_kept", obs_taddr, 32'hF000_0000);

    // Slave ready on the expiry cycle wins.
    mv[0] = 1'b1; ma[0] = 32'h5000_0000; ms[0] = 4'h0;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) begin sr = 1'b1; srd = 32'hAAAA_5555; end
      step();
    end
    check("t4_m0_ready", 32'(obs_rdy[0]), 32'd1);
    check("t4_m0_rdata", obs_rdata[0], 32'hAAAA_5555);
    idle_inputs();
    step();
    check("t4_no_err", 32'(obs_err), 32'd0);

    // Reset while m0 waits: no ready, then m0 wins the tie after reset.
    mv[0] = 1'b1; ma[0] = 32'h6000_0000;
    step();
    mv[1] = 1'b1; ma[1] = 32'h7000_0000;
    step();
    rst_in = 1'b1; step(); rst_in = 1'b0;
    step();
    check("t5_valid_after_rst", 32'(obs_valid), 32'd0);
    check("t5_m0_no_ready", 32'(obs_rdy[0]), 32'd0);
    step();
    check("t5_regrant_m0", obs_addr, 32'h6000_0000);
    check("t5_regrant_valid", 32'(obs_valid), 32'd1);
    idle_inputs();
    step();

    // Randomized traffic.
    stall = 1'b0;
    c0 = n_fail;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mv[i] || exp_rdy[i]) begin
          mv[i] = ($urandom_range(0, 2) == 0);
          ma[i] = $urandom; mw[i] = $urandom; ms[i] = 4'($urandom_range(0, 15));
        end else if ($urandom_range(0, 63) == 0) begin
          mv[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 39) == 0) stall = ~stall;
      sr     = !stall && ($urandom_range(0, 3) == 0);
      srd    = $urandom;
      clr_in = ($urandom_range(0, 15) == 0);
      rst_in = ($urandom_range(0, 499) == 0);
      step();
    end
    if (n_fail != c0) $display("random phase saw %0d new errors", n_fail - c0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
